ysyx_22051013_ctrl_fsm: RTL and testbench
=========================================

YSYX_22051013_CTRL_FSM -- requirements
Module: ysyx_22051013_ctrl_fsm

Interface
REQ-001 Parameter: TIMEOUT, default 255; maximum wait cycles for a memory handshake before error.
REQ-002 Port: clk  in  1  core clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req  out  1  instruction fetch request.
REQ-005 Port: imem_ready  in  1  fetch data valid; instruction stable on the inst bus this cycle.
REQ-006 Port: ir_we  out  1  latch the fetched instruction into the instruction register.
REQ-007 Port: dec_is_mem, dec_is_store, dec_jump, dec_ebreak  in  1 each  decoder flags for the current instruction register.
REQ-008 Port: dmem_req  out  1  data memory request; dmem_we  out  1  store strobe.
REQ-009 Port: dmem_ready  in  1  data memory access complete.
REQ-010 Port: rf_we  out  1  register file write enable.
REQ-011 Port: pc_we  out  1  PC update strobe; pc_sel  out  1  selects the jump target (1) or PC+4 (0).
REQ-012 Port: halted  out  1  ebreak reached; err  out  1  handshake timeout.
REQ-013 Port: state_o  out  3  current state encoding, for debug and tracing.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-015 Outputs are combinational decodes of the registered state and the ready inputs; the block has no other output registers.
REQ-016 IDLE: all strobes 0; goes to FETCH on the next cycle unconditionally.
REQ-017 FETCH: imem_req=1.
- imem_ready=1: ir_we=1 in that same cycle, then go to DECODE.
- Otherwise: stay in FETCH.
REQ-018 DECODE: all strobes 0.
- dec_ebreak=1: go to HALT.
- Otherwise: go to EXEC.
REQ-019 EXEC: all strobes 0.
- dec_is_mem=1: go to MEM.
- Otherwise: go to WB.
REQ-020 MEM: dmem_req=1 and dmem_we=dec_is_store.
- dmem_ready=1: go to WB.
- Otherwise: stay in MEM.
REQ-021 WB: pc_we=1, pc_sel=dec_jump, rf_we=!dec_is_store; go to FETCH.
REQ-022 HALT: halted=1; all other strobes 0; sticky until reset.
REQ-023 ERR: err=1; all other strobes 0; sticky until reset.
REQ-024 Wait counter, 8 bits minimum:
- Cleared on every entry to FETCH or MEM.
- Increments each cycle spent in FETCH or MEM without ready.
- Reaching TIMEOUT without ready: go to ERR on the next edge.
REQ-025 Ready asserted in the same cycle the counter equals TIMEOUT: ready wins and the normal transition is taken.
REQ-026 imem_ready outside FETCH and dmem_ready outside MEM are ignored and produce no strobe.
REQ-027 Exactly one pc_we pulse per completed instruction; ir_we and pc_we are never asserted in the same cycle.
REQ-028 Minimum latency is 5 cycles for non-memory instructions (FETCH, DECODE, EXEC, WB, FETCH) and 6 cycles for memory instructions, when ready returns in the first request cycle.

Reset
REQ-029 While rst=0: state=IDLE, counter=0, and every output is 0 (state_o = IDLE code), asynchronously.
REQ-030 Reset asserted mid-handshake (FETCH or MEM): request deasserts immediately; no ir_we, rf_we or pc_we is emitted.
REQ-031 After reset release: first imem_req is asserted in the second cycle (IDLE, then FETCH).

Structure
REQ-032 State encodings (3-bit) and the TIMEOUT default are defined in define.v with the ysyx_22051013_ prefix; the debug and trace code reuses them.
REQ-033 No sub-module is used; the timeout counter is inline.
REQ-034 Estimated size is 150-250 lines of RTL.

Verification
REQ-035 addi with imem_ready at the first FETCH cycle:
- ir_we at cycle 1 after IDLE.
- pc_we=1, rf_we=1, pc_sel=0 at cycle 4.
- imem_req re-asserted at cycle 5.
REQ-036 jal (dec_jump=1):
- WB asserts pc_sel=1, pc_we=1, rf_we=1.
REQ-037 sd (dec_is_mem=1, dec_is_store=1), dmem_ready after 3 wait cycles:
- dmem_req=1 and dmem_we=1 for 4 cycles.
- WB asserts rf_we=0, pc_we=1.
REQ-038 ebreak (dec_ebreak=1):
- DECODE transitions to HALT and halted=1 stays set.
- No further imem_req is issued until rst pulses low.
REQ-039 imem_ready held 0 with TIMEOUT=4:
- ERR entered after 4 wait cycles; err=1; imem_req=0.
- Repeat with ready arriving exactly at count 4: DECODE is entered instead of ERR.
REQ-040 rst pulled low while in MEM with dmem_req=1:
- All outputs 0 immediately.
- After release: IDLE, then FETCH.

Source files
------------

// File: rtl/ysyx_22051013_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_ctrl_fsm_pkg
// Description : Shared definitions for the multi-cycle core control FSM:
//               3-bit state encodings (also used by debug/trace logic),
//               the default handshake timeout and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22051013_ctrl_fsm_pkg;

    // State encodings. The numeric values are visible on state_o, so trace
    // tooling may rely on them; do not renumber.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // Default maximum number of wait cycles for a memory handshake.
    localparam int c_timeout_default = 255;

    // Wait-counter width: at least 8 bits, wider if the timeout needs it.
    function automatic int cnt_width(input int timeout);
        return (timeout < 256) ? 8 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22051013_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_ctrl_fsm
// Description : Multi-cycle control FSM for a simple core.
//               IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH ...
//               ebreak in DECODE parks the machine in HALT; a memory
//               handshake that exceeds TIMEOUT wait cycles parks it in ERR.
//               Both terminal states are left only through reset.
// Ports       : clk          - core clock, rising edge
//               rst          - asynchronous reset, active low
//               imem_req     - instruction fetch request (FETCH)
//               imem_ready   - fetch data valid
//               ir_we        - latch fetched instruction into IR
//               dec_is_mem   - decoded instruction accesses data memory
//               dec_is_store - decoded instruction is a store
//               dec_jump     - decoded instruction redirects the PC
//               dec_ebreak   - decoded instruction is ebreak
//               dmem_req     - data memory request (MEM)
//               dmem_we      - data memory store strobe
//               dmem_ready   - data memory access complete
//               rf_we        - register file write enable (WB)
//               pc_we        - PC update strobe (WB)
//               pc_sel       - 1: jump target, 0: PC+4
//               halted       - ebreak reached (sticky)
//               err          - handshake timeout (sticky)
//               state_o      - current state encoding for debug/trace
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051013_ctrl_fsm
    import ysyx_22051013_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       ir_we,
    input  logic       dec_is_mem,
    input  logic       dec_is_store,
    input  logic       dec_jump,
    input  logic       dec_ebreak,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       rf_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       halted,
    output logic       err,
    output logic [2:0] state_o
);

    localparam int                 c_cnt_w   = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_timeout;

    // The counter holds the number of unanswered request cycles already
    // spent in the current FETCH/MEM visit. Ready in the cycle where it
    // equals TIMEOUT still completes the handshake normally.
    assign w_timeout = (r_cnt >= c_timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and output decode. The counter defaults to zero, so it is
    // automatically cleared on every entry to FETCH or MEM; it only counts
    // while a request stays unanswered in one of those states.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we       = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_DECODE: begin
                w_state_nxt = dec_ebreak ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                w_state_nxt = dec_is_mem ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_is_store;
                if (dmem_ready) begin
                    w_state_nxt = ST_WB;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_WB: begin
                pc_we       = 1'b1;
                pc_sel      = dec_jump;
                rf_we       = ~dec_is_store;
                w_state_nxt = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            ST_ERR: begin
                err = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051013_ctrl_fsm
// Description : Self-checking bench for ysyx_22051013_ctrl_fsm. Instructions
//               are described at transaction level (kind, fetch wait, memory
//               wait) and expanded into the expected per-cycle output trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_ctrl_fsm;
    import ysyx_22051013_ctrl_fsm_pkg::*;

    localparam int TO = 4;

    localparam int K_ALU   = 0;
    localparam int K_JUMP  = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_EBRK  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dec_is_mem = 1'b0;
    logic       dec_is_store = 1'b0;
    logic       dec_jump = 1'b0;
    logic       dec_ebreak = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel;
    logic       halted, err;
    logic [2:0] state_o;
    logic [11:0] obs;

    ysyx_22051013_ctrl_fsm #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .ir_we        (ir_we),
        .dec_is_mem   (dec_is_mem),
        .dec_is_store (dec_is_store),
        .dec_jump     (dec_jump),
        .dec_ebreak   (dec_ebreak),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .halted       (halted),
        .err          (err),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
                  halted, err, state_o};

    typedef struct {
        logic       im;
        logic       dm;
        logic       ism;
        logic       iss;
        logic       jmp;
        logic       ebk;
        logic [8:0] exp;
        logic [2:0] st;
    } vec_t;

    vec_t q[$];
    vec_t tbl[9];
    int   checks = 0;
    int   failures = 0;

    // Expected outputs in obs bit order (state appended separately).
    function automatic logic [8:0] o(input logic req, input logic irwe,
                                     input logic dreq, input logic dwe,
                                     input logic rfwe, input logic pcwe,
                                     input logic pcsel, input logic hlt,
                                     input logic er);
        return {req, irwe, dreq, dwe, rfwe, pcwe, pcsel, hlt, er};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t mkv(input logic im, input logic dm,
                                 input logic ism, input logic iss,
                                 input logic jmp, input logic ebk,
                                 input logic [8:0] exp, input logic [2:0] st);
        vec_t v;
        v.im = im; v.dm = dm; v.ism = ism; v.iss = iss;
        v.jmp = jmp; v.ebk = ebk; v.exp = exp; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic push(input vec_t v);
        q.push_back(v);
    endtask

    // Apply queued cycles: inputs driven after the falling edge, outputs
    // sampled 1 time unit later, well away from the rising edge.
    task automatic run(input string name);
        while (q.size() > 0) begin
            vec_t v;
            v = q.pop_front();
            @(negedge clk);
            imem_ready   = v.im;
            dmem_ready   = v.dm;
            dec_is_mem   = v.ism;
            dec_is_store = v.iss;
            dec_jump     = v.jmp;
            dec_ebreak   = v.ebk;
            #1;
            check(name, obs, {v.exp, v.st});
        end
    endtask

    task automatic push_terminal(input logic [8:0] exp, input logic [2:0] st);
        for (int i = 0; i < 4; i++)
            push(mkv(rb(), rb(), rb(), rb(), rb(), rb(), exp, st));
    endtask

    // Reference model: expand one instruction into its expected cycle trace.
    // fw/mw = number of unanswered request cycles before ready arrives;
    // more than TO of them ends in the error state.
    task automatic gen_instr(input int kind, input int fw, input int mw,
                             output bit term);
        logic ism, iss, jmp, ebk;
        ism  = (kind == K_LOAD) || (kind == K_STORE);
        iss  = (kind == K_STORE);
        jmp  = (kind == K_JUMP);
        ebk  = (kind == K_EBRK);
        term = 1'b0;

        for (int i = 0; i < fw && i <= TO; i++)
            push(mkv(1'b0, rb(), rb(), rb(), rb(), rb(),
                     o(1,0,0,0,0,0,0,0,0), ST_FETCH));
        if (fw > TO) begin
            push_terminal(o(0,0,0,0,0,0,0,0,1), ST_ERR);
            term = 1'b1;
            return;
        end
        push(mkv(1'b1, rb(), rb(), rb(), rb(), rb(),
                 o(1,1,0,0,0,0,0,0,0), ST_FETCH));

        push(mkv(rb(), rb(), ism, iss, jmp, ebk, 9'd0, ST_DECODE));
        if (ebk) begin
            push_terminal(o(0,0,0,0,0,0,0,1,0), ST_HALT);
            term = 1'b1;
            return;
        end

        push(mkv(rb(), rb(), ism, iss, jmp, ebk, 9'd0, ST_EXEC));
        if (ism) begin
            for (int i = 0; i < mw && i <= TO; i++)
                push(mkv(rb(), 1'b0, ism, iss, jmp, ebk,
                         o(0,0,1,iss,0,0,0,0,0), ST_MEM));
            if (mw > TO) begin
                push_terminal(o(0,0,0,0,0,0,0,0,1), ST_ERR);
                term = 1'b1;
                return;
            end
            push(mkv(rb(), 1'b1, ism, iss, jmp, ebk,
                     o(0,0,1,iss,0,0,0,0,0), ST_MEM));
        end

        push(mkv(rb(), rb(), ism, iss, jmp, ebk,
                 o(0,0,0,0,~iss,1,jmp,0,0), ST_WB));
    endtask

    task automatic push_idle();
        push(mkv(rb(), rb(), rb(), rb(), rb(), rb(), 9'd0, ST_IDLE));
    endtask

    // Pulse reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset(input bit mid_mem);
        @(negedge clk);
        imem_ready = rb(); dec_jump = rb(); dec_ebreak = rb();
        if (mid_mem) begin
            dmem_ready = 1'b0; dec_is_mem = 1'b1; dec_is_store = 1'b1;
            #1;
            check("mem_before_reset", obs, {o(0,0,1,1,0,0,0,0,0), ST_MEM});
        end
        rst = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check("reset_async", obs, {9'd0, ST_IDLE});
        @(posedge clk);
        #1;
        check("reset_hold", obs, {9'd0, ST_IDLE});
        #1;
        rst = 1'b1;
        push_idle();
    endtask

    initial begin
        bit term;
        int r, kind, fw, mw;

        // addi then jal, starting from reset release
        tbl[0] = mkv(1,1,0,0,0,0, o(0,0,0,0,0,0,0,0,0), ST_IDLE);
        tbl[1] = mkv(1,0,0,0,0,0, o(1,1,0,0,0,0,0,0,0), ST_FETCH);
        tbl[2] = mkv(0,1,0,0,0,0, o(0,0,0,0,0,0,0,0,0), ST_DECODE);
        tbl[3] = mkv(1,1,0,0,0,0, o(0,0,0,0,0,0,0,0,0), ST_EXEC);
        tbl[4] = mkv(1,1,0,0,0,0, o(0,0,0,0,1,1,0,0,0), ST_WB);
        tbl[5] = mkv(1,0,1,1,1,0, o(1,1,0,0,0,0,0,0,0), ST_FETCH);
        tbl[6] = mkv(0,1,0,0,1,0, o(0,0,0,0,0,0,0,0,0), ST_DECODE);
        tbl[7] = mkv(1,0,0,0,1,0, o(0,0,0,0,0,0,0,0,0), ST_EXEC);
        tbl[8] = mkv(0,1,0,0,1,0, o(0,0,0,0,1,1,1,0,0), ST_WB);

        // power-on reset
        @(negedge clk);
        #1;
        check("reset_initial", obs, {9'd0, ST_IDLE});
        @(posedge clk);
        #2;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) push(tbl[i]);
        run("table_addi_jal");

        gen_instr(K_STORE, 0, 3, term);
        run("sd_wait3");

        gen_instr(K_EBRK, 0, 0, term);
        run("ebreak_halt");
        do_reset(1'b0);

        gen_instr(K_ALU, TO + 1, 0, term);
        run("fetch_timeout");
        do_reset(1'b0);

        gen_instr(K_ALU, TO, 0, term);
        run("fetch_ready_at_limit");

        gen_instr(K_LOAD, 0, TO, term);
        run("mem_ready_at_limit");

        gen_instr(K_LOAD, 1, TO + 1, term);
        run("mem_timeout");
        do_reset(1'b0);

        // reset while a store is waiting in MEM
        push(mkv(1,0,0,0,0,0, o(1,1,0,0,0,0,0,0,0), ST_FETCH));
        push(mkv(0,0,1,1,0,0, 9'd0, ST_DECODE));
        push(mkv(0,0,1,1,0,0, 9'd0, ST_EXEC));
        push(mkv(1,0,1,1,0,0, o(0,0,1,1,0,0,0,0,0), ST_MEM));
        push(mkv(1,0,1,1,0,0, o(0,0,1,1,0,0,0,0,0), ST_MEM));
        run("mem_prefix");
        do_reset(1'b1);
        run("after_mem_reset");

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 15));
            kind = (r < 4) ? K_ALU : (r < 7) ? K_JUMP : (r < 10) ? K_LOAD :
                   (r < 15) ? K_STORE : K_EBRK;
            fw = ($urandom_range(0, 11) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            mw = ($urandom_range(0, 11) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            gen_instr(kind, fw, mw, term);
            run("random");
            if (term) begin
                do_reset(1'b0);
            end
        end
        run("random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
